// File: rtl/uart_echo_fifo.sv
// Byte FIFO between the buart receiver and transmitter: acknowledges received bytes,
// replays them whenever the transmitter is idle, and can expand CR into CR LF.
//
// state    | meaning
// RX_IDLE  | waiting for rx_valid_i; pushes or drops the byte
// RX_ACK   | rx_rd_o high for this cycle
// RX_GUARD | 2 cycles with rx_valid_i ignored while buart drops valid
// TX_IDLE  | waiting for data and an idle transmitter; pops a byte
// TX_SEND  | tx_wr_o high for this cycle
// TX_GUARD | 2 cycles before tx_busy_i is trusted again
// TX_DRAIN | waiting for tx_busy_i low; may insert LF after CR
module uart_echo_fifo #(
    parameter int DEPTH = 16,
    parameter bit CRLF  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     resetq_i,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    output logic                     rx_rd_o,
    input  logic                     tx_busy_i,
    output logic                     tx_wr_o,
    output logic [7:0]               tx_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_count_o,
    output logic                     tx_active_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [7:0]  DROP_MAX = 8'hFF;
    localparam logic [7:0]  CHAR_CR  = 8'h0D;
    localparam logic [7:0]  CHAR_LF  = 8'h0A;

    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GUARD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD, TX_DRAIN} tx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic        rx_gcnt_q, rx_gcnt_d;
    logic        tx_gcnt_q, tx_gcnt_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        rx_rd_q, rx_rd_d;
    logic        tx_wr_q, tx_wr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  drop_q, drop_d;
    logic        tx_active_q, tx_active_d;
    logic        lf_pend_q, lf_pend_d;
    logic        push;
    logic        full, empty;

    logic [7:0]  mem_q [DEPTH];

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Storage needs no reset: the pointers alone define valid contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        tx_state_d  = tx_state_q;
        rx_gcnt_d   = rx_gcnt_q;
        tx_gcnt_d   = tx_gcnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tx_data_d   = tx_data_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        lf_pend_d   = lf_pend_q;
        rx_rd_d     = 1'b0;
        tx_wr_d     = 1'b0;
        push        = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_valid_i) begin
                    if (!full) begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        overflow_d = 1'b1;
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                    rx_state_d = RX_ACK;
                    rx_rd_d    = 1'b1;
                end
            end
            RX_ACK: begin
                rx_state_d = RX_GUARD;
                rx_gcnt_d  = 1'b1;
            end
            RX_GUARD: begin
                if (rx_gcnt_q == 1'b0) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_gcnt_d = rx_gcnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        case (tx_state_q)
            TX_IDLE: begin
                if (!empty && !tx_busy_i) begin
                    tx_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    tx_state_d = TX_SEND;
                    tx_wr_d    = 1'b1;
                end
            end
            TX_SEND: begin
                tx_state_d = TX_GUARD;
                tx_gcnt_d  = 1'b1;
            end
            TX_GUARD: begin
                if (tx_gcnt_q == 1'b0) begin
                    tx_state_d = TX_DRAIN;
                end else begin
                    tx_gcnt_d = tx_gcnt_q - 1'b1;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy_i) begin
                    // The inserted LF is sent straight from here and never touches the FIFO.
                    if (CRLF && (tx_data_q == CHAR_CR) && !lf_pend_q) begin
                        tx_data_d  = CHAR_LF;
                        lf_pend_d  = 1'b1;
                        tx_state_d = TX_SEND;
                        tx_wr_d    = 1'b1;
                    end else begin
                        lf_pend_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        level_d     = wr_ptr_d - rd_ptr_d;
        tx_active_d = (tx_state_d != TX_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!resetq_i) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_IDLE;
            rx_gcnt_q   <= 1'b0;
            tx_gcnt_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rx_rd_q     <= 1'b0;
            tx_wr_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            overflow_q  <= 1'b0;
            drop_q      <= 8'h00;
            tx_active_q <= 1'b0;
            lf_pend_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            rx_gcnt_q   <= rx_gcnt_d;
            tx_gcnt_q   <= tx_gcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_data_q   <= tx_data_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            tx_active_q <= tx_active_d;
            lf_pend_q   <= lf_pend_d;
        end
    end

    assign rx_rd_o      = rx_rd_q;
    assign tx_wr_o      = tx_wr_q;
    assign tx_data_o    = tx_data_q;
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign tx_active_o  = tx_active_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: a buart-like busy model, a transmit monitor,
// table-driven single-byte vectors, hand sequences for corner cases and random streams.
module tb_uart_echo_fifo;
    localparam int DEPTH = 16;

    logic       clk      = 1'b0;
    logic       resetq   = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_busy  = 1'b0;

    logic       rx_rd, tx_wr, overflow, tx_active;
    logic [7:0] tx_data, drop_count;
    logic [4:0] level;
    logic       rx_rd0, tx_wr0, overflow0, tx_active0;
    logic [7:0] tx_data0, drop_count0;
    logic [4:0] level0;

    uart_echo_fifo #(.DEPTH(DEPTH), .CRLF(1'b1)) u_dut (
        .clk_i(clk), .resetq_i(resetq), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_rd_o(rx_rd), .tx_busy_i(tx_busy), .tx_wr_o(tx_wr), .tx_data_o(tx_data),
        .level_o(level), .overflow_o(overflow), .drop_count_o(drop_count),
        .tx_active_o(tx_active));

    uart_echo_fifo #(.DEPTH(DEPTH), .CRLF(1'b0)) u_dut_nocrlf (
        .clk_i(clk), .resetq_i(resetq), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_rd_o(rx_rd0), .tx_busy_i(tx_busy), .tx_wr_o(tx_wr0), .tx_data_o(tx_data0),
        .level_o(level0), .overflow_o(overflow0), .drop_count_o(drop_count0),
        .tx_active_o(tx_active0));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] got0_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];
    int rd_pulses  = 0;
    int max_level  = 0;
    bit force_busy = 1'b0;
    int busy_len   = 10;
    int busy_cnt   = 0;

    // Transmitter model and monitor, on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (rx_rd) rd_pulses++;
        if (int'(level) > max_level) max_level = int'(level);
        if (tx_wr) begin
            got_q.push_back(tx_data);
            total++;
            if (tx_busy) begin
                bad++;
                $display("FAIL wr_while_busy: tx_wr=1 with tx_busy=1 sampled, required no strobe");
            end
        end
        if (tx_wr0) got0_q.push_back(tx_data0);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_wr) busy_cnt = busy_len;
        tx_busy = force_busy || (busy_cnt > 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        resetq = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        resetq = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rx_rd) begin
                seen = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!seen) check("rx_ack_timeout", 0, 1);
    endtask

    task automatic wait_got(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (got_q.size() < n) check("tx_timeout", got_q.size(), n);
    endtask

    task automatic push_expected(input logic [7:0] b);
        exp_q.push_back(b);
        if (b == 8'h0D) exp_q.push_back(8'h0A);
        exp0_q.push_back(b);
    endtask

    task automatic compare_streams(input string name, input int s, input int s0, input int budget);
        wait_got(s + exp_q.size(), budget);
        repeat (30) tick();
        check({name, "_count"}, got_q.size() - s, exp_q.size());
        for (int i = 0; i < exp_q.size() && s + i < got_q.size(); i++)
            check({name, "_byte"}, int'(got_q[s + i]), int'(exp_q[i]));
        if (exp0_q.size() > 0) begin
            check({name, "_nocrlf_count"}, got0_q.size() - s0, exp0_q.size());
            for (int i = 0; i < exp0_q.size() && s0 + i < got0_q.size(); i++)
                check({name, "_nocrlf_byte"}, int'(got0_q[s0 + i]), int'(exp0_q[i]));
        end
    endtask

    typedef struct {
        logic [7:0] din;
        int         n_crlf;
        logic [7:0] e0;
        logic [7:0] e1;
        int         n_plain;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int s, s0, rp0, idx;
        logic [7:0] b;

        tbl[0] = '{8'h41, 1, 8'h41, 8'h00, 1};
        tbl[1] = '{8'h0D, 2, 8'h0D, 8'h0A, 1};
        tbl[2] = '{8'h0A, 1, 8'h0A, 8'h00, 1};
        tbl[3] = '{8'h00, 1, 8'h00, 8'h00, 1};
        tbl[4] = '{8'hFF, 1, 8'hFF, 8'h00, 1};

        // Reset values, observed while reset is held.
        tick();
        check("rst_rx_rd", rx_rd, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_tx_active", tx_active, 0);
        do_reset();

        // Single byte with exact latencies.
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        tick();
        check("sb_rx_rd", rx_rd, 1);
        check("sb_level_push", level, 1);
        check("sb_no_early_wr", tx_wr, 0);
        rx_valid = 1'b0;
        tick();
        check("sb_rx_rd_one_cycle", rx_rd, 0);
        check("sb_tx_wr", tx_wr, 1);
        check("sb_tx_data", tx_data, 8'h41);
        check("sb_level_pop", level, 0);
        check("sb_tx_active", tx_active, 1);
        tick();
        check("sb_tx_wr_one_cycle", tx_wr, 0);
        check("sb_tx_data_held", tx_data, 8'h41);
        repeat (30) tick();
        check("sb_tx_idle", tx_active, 0);

        // Table-driven single-byte vectors on both CRLF settings.
        for (int v = 0; v < 5; v++) begin
            s  = got_q.size();
            s0 = got0_q.size();
            send_byte(tbl[v].din);
            repeat (45) tick();
            check("tbl_count", got_q.size() - s, tbl[v].n_crlf);
            if (got_q.size() > s) check("tbl_byte0", got_q[s], tbl[v].e0);
            if (tbl[v].n_crlf > 1 && got_q.size() > s + 1) check("tbl_byte1", got_q[s + 1], tbl[v].e1);
            check("tbl_nocrlf_count", got0_q.size() - s0, tbl[v].n_plain);
            if (got0_q.size() > s0) check("tbl_nocrlf_byte0", got0_q[s0], tbl[v].e0);
        end

        // Pointer wrap: 100 bytes with buart-like pacing.
        do_reset();
        max_level = 0;
        busy_len = 10;
        exp_q.delete();
        exp0_q.delete();
        s  = got_q.size();
        s0 = got0_q.size();
        for (int i = 0; i < 100; i++) begin
            b = 8'(i);
            push_expected(b);
            send_byte(b);
            repeat (14) tick();
        end
        compare_streams("wrap", s, s0, 3000);
        check("wrap_max_level", int'(max_level <= DEPTH), 1);
        check("wrap_no_drops", drop_count, 0);

        // Random stream, CR-heavy, paced so nothing is dropped.
        do_reset();
        exp_q.delete();
        exp0_q.delete();
        s  = got_q.size();
        s0 = got0_q.size();
        for (int i = 0; i < 60; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
            push_expected(b);
            send_byte(b);
            repeat ($urandom_range(25, 40)) tick();
        end
        compare_streams("rand", s, s0, 3000);
        check("rand_no_drops", drop_count, 0);
        check("rand_level", level, 0);

        // Overflow: transmitter held busy, 20 bytes into 16 entries.
        do_reset();
        force_busy = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        exp0_q.delete();
        rp0 = rd_pulses;
        s   = got_q.size();
        for (int i = 0; i < 20; i++) begin
            b = 8'h20 + 8'(i);
            if (i < DEPTH) exp_q.push_back(b);
            send_byte(b);
        end
        repeat (5) tick();
        check("ovf_level", level, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_count", drop_count, 20 - DEPTH);
        check("ovf_rd_pulses", rd_pulses - rp0, 20);
        check("ovf_no_tx", got_q.size() - s, 0);
        force_busy = 1'b0;
        compare_streams("ovf", s, got0_q.size(), 1500);
        check("ovf_flag_sticky", overflow, 1);

        // Drop counter saturation.
        do_reset();
        force_busy = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        exp0_q.delete();
        s = got_q.size();
        for (int i = 0; i < DEPTH + 250; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < DEPTH) push_expected(b);
            send_byte(b);
        end
        repeat (5) tick();
        check("sat_drop_250", drop_count, 250);
        for (int i = 0; i < 50; i++) send_byte(8'h55);
        repeat (5) tick();
        check("sat_drop_255", drop_count, 255);
        for (int i = 0; i < 10; i++) send_byte(8'hAA);
        repeat (5) tick();
        check("sat_drop_stays", drop_count, 255);
        check("sat_level", level, DEPTH);
        exp0_q.delete();
        force_busy = 1'b0;
        compare_streams("sat", s, got0_q.size(), 1500);

        // Reset during TX_GUARD with five bytes still queued.
        do_reset();
        busy_len = 20;
        force_busy = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
        repeat (5) tick();
        check("mid_level_pre", level, 6);
        force_busy = 1'b0;
        idx = 0;
        while (!tx_wr && idx < 50) begin
            tick();
            idx++;
        end
        check("mid_tx_wr_seen", tx_wr, 1);
        check("mid_level", level, 5);
        tick();
        resetq = 1'b0;
        tick();
        check("mid_rst_rx_rd", rx_rd, 0);
        check("mid_rst_tx_wr", tx_wr, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_drop_count", drop_count, 0);
        check("mid_rst_tx_active", tx_active, 0);
        resetq = 1'b1;
        s = got_q.size();
        repeat (40) tick();
        check("mid_no_tx_after_reset", got_q.size() - s, 0);
        check("mid_level_after", level, 0);
        send_byte(8'h5A);
        wait_got(s + 1, 80);
        if (got_q.size() > s) check("mid_new_byte", got_q[s], 8'h5A);
        busy_len = 10;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
